// File: rtl/pipe_pkg.sv
// Shared types and helpers for the execute-stage hazard controller.
// Defines forwarding-select encodings and the per-stage destination shadow record.
package pipe_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ld;
  } stage_info;

  // x0 is hardwired zero, so it never counts as a produced value.
  function automatic logic dest_match(stage_info s, logic [REG_AW-1:0] r);
    return s.v && s.we && (s.rd != '0) && (s.rd == r);
  endfunction

  // The younger producer (in EX) wins over the older one (in MEM).
  function automatic logic [1:0] fwd_sel(stage_info ex, stage_info mem,
                                         logic use_r, logic [REG_AW-1:0] r);
    if (!use_r)                        return FWD_RF;
    if (dest_match(ex, r) && !ex.ld)   return FWD_MEM;
    if (dest_match(mem, r))            return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: tracks EX/MEM/WB destinations to drive
// operand forwarding, load-use stalls, jump-redirect flushes and perf counters.
module ex_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_write_reg,
  input  logic              id_reg_wrenable,
  input  logic              id_mem_to_reg,
  input  logic              ex_redirect,
  output logic              pc_wrenable,
  output logic              if_id_wrenable,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              ex_valid,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  stage_info  ex_q, ex_d, mem_q, wb_q;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic       redirect, load_use, bubble;
  logic       stall_inc;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    redirect = ex_redirect && ex_q.v;
    load_use = id_valid && ex_q.ld &&
               ((id_use_rs1 && dest_match(ex_q, id_rs1)) ||
                (id_use_rs2 && dest_match(ex_q, id_rs2)));
    bubble   = redirect || load_use;

    pc_wrenable    = 1'b1;
    if_id_wrenable = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    if (redirect) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_wrenable    = 1'b0;
      if_id_wrenable = 1'b0;
      id_ex_bubble   = 1'b1;
    end

    ex_d    = '0;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (!bubble) begin
      ex_d = '{v: id_valid, rd: id_write_reg, we: id_reg_wrenable, ld: id_mem_to_reg};
      if (id_valid) begin
        fwd_a_d = fwd_sel(ex_q, mem_q, id_use_rs1, id_rs1);
        fwd_b_d = fwd_sel(ex_q, mem_q, id_use_rs2, id_rs2);
      end
    end
  end

  // Shadow stages always advance; only IF/ID is ever held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a    = fwd_a_q;
  assign fwd_b    = fwd_b_q;
  assign ex_valid = ex_q.v;

  // A redirect squashes the ID instruction, so a coincident load-use is not a stall.
  assign stall_inc = load_use && !redirect;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect),
    .count (flush_count)
  );

  // WB shadow and MEM load flag are kept for pipeline visibility; no decision here reads them.
  logic unused_shadow;
  assign unused_shadow = ^{wb_q, mem_q.ld};

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
Pipeline controller that sequences the execute stage: the block owns the execute stage's operand forwarding, load-use stalls and jump-redirect flushes. It keeps a shadow of per-stage destination info for EX, MEM and WB. From that shadow it drives operand-forwarding selects for the EX ALU, hold/flush strobes for PC, IF/ID and ID/EX, and saturating performance counters. It sits beside the IF/ID/EX/MEM/WB pipeline registers and consumes decode info from ID plus the jump-resolution result from EX.

Parameters:
REG_AW, 5, register-file address width (32 architectural registers; x0 hardwired zero)
CNT_W, 16, width of each saturating performance counter

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID stage holds a real instruction
id_rs1  input  REG_AW  ID source register 1
id_rs2  input  REG_AW  ID source register 2
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
id_write_reg  input  REG_AW  ID destination register
id_reg_wrenable  input  1  ID instruction writes the register file
id_mem_to_reg  input  1  ID instruction is a load
ex_redirect  input  1  EX instruction is a taken jump/jal/jalr; PC must load the EX target
pc_wrenable  output  1  PC may advance
if_id_wrenable  output  1  IF/ID register may capture
if_id_flush  output  1  IF/ID loads a bubble
id_ex_bubble  output  1  ID/EX loads a bubble instead of the ID instruction
fwd_a  output  2  EX operand-1 source select
fwd_b  output  2  EX operand-2 (register) source select
ex_valid  output  1  EX holds a real instruction; gates reg_wrenable and mem_wrenable downstream
stall_count  output  CNT_W  load-use stall cycles
flush_count  output  CNT_W  redirect events

Behaviour:
- Shadow stages: {v, rd, we, ld} for each of EX, MEM and WB. Every clock: WB<=MEM; MEM<=EX. EX<=ID info, or all-zero when id_ex_bubble=1.
- Shadow stages never hold, because only IF/ID is ever stalled.
- Destination-match condition (wr): v && we && rd!=0. x0 never matches, never forwards and never stalls.
- Load-use (combinational): EX.v && EX.ld && matches(EX.rd) on a used ID source with id_valid=1.
- Redirect: ex_redirect && EX.v. Any ex_redirect while EX.v=0 is ignored.
- Outputs, combinational, same cycle:
  - On redirect: if_id_flush=1, id_ex_bubble=1, pc_wrenable=1, if_id_wrenable=1.
  - Else on load-use: pc_wrenable=0, if_id_wrenable=0, id_ex_bubble=1.
  - Else: pc_wrenable=1, if_id_wrenable=1, all strobes 0.
- Redirect beats a simultaneous load-use: the ID instruction is squashed, no stall is taken, and stall_count is not incremented.
- Forwarding selects are registered. They are computed at the ID->EX transition and are valid throughout the instruction's EX cycle.
  - Encodings: FWD_RF=00, FWD_MEM=01 (EX/MEM alu_res), FWD_WB=10 (MEM/WB write-back data). Value 11 is never driven.
  - Next fwd_a uses id_use_rs1 and id_rs1.
  - If the current EX matches and is not a load, select FWD_MEM.
  - Else if the current MEM matches, select FWD_WB.
  - Else select FWD_RF.
  - fwd_b is identical using rs2.
  - The nearer (younger) producer wins.
  - The load case cannot occur when it would need FWD_MEM: the load-use stall first moves the load to MEM, after which it yields FWD_WB.
  - Whenever a bubble is loaded into EX, fwd_a and fwd_b load 00.
- Register-file write in WB and read in ID in the same cycle is handled by regfile write-through, not by this block.
- Counters:
  - stall_count increments on each load-use stall cycle.
  - flush_count increments on each redirect cycle.
  - Both saturate at all-ones and never wrap.
- Reset (async, any time including mid-stall): all shadow v=0; fwd_a=fwd_b=00; counters=0; ex_valid=0.
  - Consequently pc_wrenable=1, if_id_wrenable=1, and if_id_flush=id_ex_bubble=0 while in reset and after release.
- Latency: a stall costs exactly 1 cycle; a redirect costs 2 squashed instructions.

Decomposition:
- Shared package pipe_pkg holds:
  - FWD_RF, FWD_MEM, FWD_WB localparams
  - REG_AW
  - stage_info struct {v, rd, we, ld}
- One sub-module is natural: sat_counter (params W; ports clk, rst_n, inc, count), instantiated twice.

Test Plan:
- Load-use: lw x5 in EX, ID add x6,x5,x1 -> one cycle with pc_wrenable=0, if_id_wrenable=0, id_ex_bubble=1, stall_count=1. Next cycle add in EX with fwd_a=10.
- Priority: addi x3 in MEM and sub x3 in EX, ID reads x3 in both rs1 and rs2 -> next cycle fwd_a=01, fwd_b=01.
- x0: producer writes x0 (we=1) in EX, ID uses rs1=x0 after a load to x0 -> no stall, fwd_a=00.
- Redirect plus load-use in the same cycle: EX jal with ex_redirect=1 while the load-use condition is also true -> if_id_flush=1, id_ex_bubble=1, pc_wrenable=1, flush_count+1, stall_count unchanged. The next EX is a bubble (ex_valid=0).
- Saturation with CNT_W=4: 20 back-to-back redirects -> flush_count stops at 15.
- Async reset asserted mid-stall, between clock edges -> immediately pc_wrenable=1, fwd_a=fwd_b=00, counters=0, ex_valid=0. A stray ex_redirect after release is ignored.
